tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux4.sv | 85 ++++++++
 tb/tb_tdm_demux4.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot TDM demultiplexer with sync-based framing.
// A sync-qualified beat marks slot 0.  Beats are collected into shadow
// slots, and the whole frame is published on q when the slot-3 beat arrives.
module tdm_demux4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               sync,
  input  logic [WIDTH-1:0]   din,
  output logic [4*WIDTH-1:0] q,
  output logic               frame_done,
  output logic [1:0]         s,
  output logic               locked,
  output logic               err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh0, sh1, sh2;

  // locked is a direct decode of the state register, so it has no extra delay
  assign locked = (state == LOCKED);

  // Framing FSM, slot counter, shadow slots and frame output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      s          <= 2'd0;
      sh0        <= '0;
      sh1        <= '0;
      sh2        <= '0;
      q          <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (valid) begin
        case (state)
          HUNT: begin
            // Only a sync beat can start a frame; anything else is dropped
            if (sync) begin
              sh0   <= din;
              s     <= 2'd1;
              state <= LOCKED;
            end
          end
          LOCKED: begin
            if (sync && (s != 2'd0)) begin
              // Early sync: abandon the partial frame and restart at slot 0
              err <= 1'b1;
              sh0 <= din;
              s   <= 2'd1;
            end else if (!sync && (s == 2'd0)) begin
              // Missing sync where slot 0 was due: drop the beat and re-hunt
              err   <= 1'b1;
              s     <= 2'd0;
              state <= HUNT;
            end else begin
              case (s)
                2'd0: sh0 <= din;
                2'd1: sh1 <= din;
                2'd2: sh2 <= din;
                default: begin
                  // Slot 3 comes straight from din so q loads on this edge
                  q          <= {din, sh2, sh1, sh0};
                  frame_done <= 1'b1;
                end
              endcase
              s <= s + 2'd1;
            end
          end
          default: begin
            state <= HUNT;
            s     <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed framing scenarios plus randomized traffic, checked
// every cycle against a queue-based frame model.
module tb_tdm_demux4;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid;
  logic           sync;
  logic [W-1:0]   din;
  logic [4*W-1:0] q;
  logic           frame_done;
  logic [1:0]     s;
  logic           locked;
  logic           err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a list of beats collected so far in the current frame
  bit             m_locked;
  logic [W-1:0]   m_part[$];
  logic [4*W-1:0] m_q;
  bit             m_fd;
  bit             m_err;
  int             fd_count;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .valid(valid), .sync(sync), .din(din),
    .q(q), .frame_done(frame_done), .s(s), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_part.delete();
    m_q = '0;
    m_fd = 0;
    m_err = 0;
  endtask

  // One accepted-beat step of the model, following the framing rules directly
  task automatic model_edge(input bit v, input bit sy, input logic [W-1:0] d);
    m_fd = 0;
    m_err = 0;
    if (!v) return;
    if (!m_locked) begin
      if (sy) begin
        m_part.delete();
        m_part.push_back(d);
        m_locked = 1;
      end
    end else if (sy) begin
      if (m_part.size() != 0) m_err = 1;
      m_part.delete();
      m_part.push_back(d);
    end else if (m_part.size() == 0) begin
      m_err = 1;
      m_locked = 0;
    end else begin
      m_part.push_back(d);
      if (m_part.size() == 4) begin
        for (int k = 0; k < 4; k++) m_q[k*W +: W] = m_part[k];
        m_fd = 1;
        m_part.delete();
      end
    end
  endtask

  task automatic compare_all();
    check("q", 32'(q), 32'(m_q));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("err", 32'(err), 32'(m_err));
    check("locked", 32'(locked), 32'(m_locked));
    check("s", 32'(s), m_locked ? 32'(m_part.size()) : 32'd0);
    check("err_fd_exclusive", 32'(err & frame_done), 32'd0);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare at negedge
  task automatic step(input bit v, input bit sy, input logic [W-1:0] d);
    valid = v;
    sync  = sy;
    din   = d;
    @(posedge clk);
    model_edge(v, sy, d);
    @(negedge clk);
    if (frame_done) fd_count++;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = 1'b0;
    sync = 1'b0;
    din = '0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    valid = 1'b0;
    sync = 1'b0;
    din = '0;
    fd_count = 0;
    @(negedge clk);

    // Basic frame
    do_reset();
    step(1, 1, 4'hA); step(1, 0, 4'hB); step(1, 0, 4'hC); step(1, 0, 4'hD);
    check("basic_q", 32'(q), 32'h0000DCBA);
    check("basic_fd", 32'(frame_done), 32'd1);
    check("basic_s", 32'(s), 32'd0);
    check("basic_locked", 32'(locked), 32'd1);
    step(0, 0, 4'h0);
    check("basic_fd_once", 32'(frame_done), 32'd0);

    // Gapped beats, including a sync that arrives with valid low
    do_reset();
    step(1, 1, 4'hA); step(0, 1, 4'h3); step(0, 0, 4'h7);
    step(1, 0, 4'hB); step(0, 1, 4'h1);
    step(1, 0, 4'hC);
    check("gap_no_early_fd", 32'(frame_done), 32'd0);
    step(0, 0, 4'h2);
    step(1, 0, 4'hD);
    check("gap_q", 32'(q), 32'h0000DCBA);
    check("gap_fd", 32'(frame_done), 32'd1);

    // Hunt discard
    do_reset();
    step(1, 0, 4'h1);
    check("hunt_locked0", 32'(locked), 32'd0);
    check("hunt_no_err", 32'(err), 32'd0);
    step(1, 0, 4'h2);
    check("hunt_locked0b", 32'(locked), 32'd0);
    step(1, 1, 4'h5);
    check("hunt_locked1", 32'(locked), 32'd1);
    step(1, 0, 4'h6); step(1, 0, 4'h7); step(1, 0, 4'h8);
    check("hunt_q", 32'(q), 32'h00008765);

    // Resync mid-frame
    step(1, 1, 4'hE); step(1, 0, 4'h1); step(1, 0, 4'h2);
    step(1, 1, 4'h9);
    check("resync_err", 32'(err), 32'd1);
    check("resync_q_held", 32'(q), 32'h00008765);
    step(1, 0, 4'h3);
    check("resync_err_once", 32'(err), 32'd0);
    step(1, 0, 4'h4); step(1, 0, 4'h5);
    check("resync_q", 32'(q), 32'h00005439);

    // Lost sync
    step(1, 0, 4'h7);
    check("lost_err", 32'(err), 32'd1);
    check("lost_locked", 32'(locked), 32'd0);
    check("lost_s", 32'(s), 32'd0);
    check("lost_q", 32'(q), 32'h00005439);
    step(0, 0, 4'h0);
    check("lost_err_once", 32'(err), 32'd0);

    // Asynchronous reset mid-frame
    step(1, 1, 4'hF); step(1, 0, 4'hE);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_q", 32'(q), 32'd0);
    check("arst_s", 32'(s), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 4'h3);
    check("arst_needs_sync", 32'(locked), 32'd0);
    step(1, 1, 4'hF); step(1, 0, 4'hE); step(1, 0, 4'hD); step(1, 0, 4'hC);
    check("arst_q_new", 32'(q), 32'h0000CDEF);

    // Back-to-back frames: frame_done exactly once every 4 cycles
    fd_count = 0;
    for (int f = 0; f < 6; f++)
      for (int b = 0; b < 4; b++)
        step(1, b == 0, W'($urandom));
    check("b2b_fd_count", 32'(fd_count), 32'd6);

    // Randomized traffic with occasional async resets
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit sy;
      r = $urandom_range(0, 99);
      if (r < 1) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
      end else begin
        // Mostly well-formed framing with sprinkled sync errors
        if (m_locked && m_part.size() == 0) sy = ($urandom_range(0, 9) != 0);
        else if (m_locked) sy = ($urandom_range(0, 19) == 0);
        else sy = ($urandom_range(0, 2) == 0);
        step($urandom_range(0, 9) < 7, sy, W'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
